// File: rtl/mem_if_pkg.sv
// mem_if_pkg: FSM encoding and default timeout shared by the initiator, responder and bench.
package mem_if_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
    localparam int DEFAULT_TIMEOUT = 16;
endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: counts enabled cycles; expired flags the LIMIT-th enabled cycle.
module mem_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] count;
    always_ff @(posedge clock)
        count <= clear ? '0 : enable ? count + W'(1) : count;
    assign expired = enable && count == W'(LIMIT - 1);
endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: MEM-stage load/store initiator with alignment check, ack wait and timeout.
module mem_initiator
    import mem_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic        clock,
    input  logic        cpu_rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        addr_err,
    output logic        timeout_err,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    state_t state;
    logic   req, aligned, accept, expired;
    assign req     = req_read | req_write;
    assign aligned = req_addr[1:0] == 2'b00;
    assign accept  = state == IDLE && req && aligned;
    assign stall   = !cpu_rst && (accept || state == ACCESS || (state == RELEASE && mem_ack));
    mem_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clock  (clock),
        .clear  (cpu_rst || state != ACCESS),
        .enable (state == ACCESS),
        .expired(expired)
    );
    // mem_we doubles as the latched write flag for the whole access
    always_ff @(posedge clock) begin
        if (cpu_rst) begin
            state       <= IDLE;
            mem_cs      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata       <= '0;
            addr_err    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            addr_err    <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= ACCESS;
                        mem_cs    <= 1'b1;
                        mem_we    <= req_write;
                        mem_addr  <= req_addr;
                        mem_wdata <= req_wdata;
                    end else begin
                        addr_err <= req && !aligned;
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state  <= RELEASE;
                        mem_cs <= 1'b0;
                        mem_we <= 1'b0;
                        if (!mem_we)
                            rdata <= mem_rdata;
                    end else if (expired) begin
                        state       <= RELEASE;
                        mem_cs      <= 1'b0;
                        mem_we      <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (!mem_ack)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_initiator.sv
// tb_mem_initiator: randomized transactions against a per-transaction timeline model.
module tb_mem_initiator;
    import mem_if_pkg::*;
    localparam int T = DEFAULT_TIMEOUT;

    logic        clock = 1'b0;
    logic        cpu_rst, req_read, req_write, mem_ack;
    logic [31:0] req_addr, req_wdata, mem_rdata;
    logic        stall, addr_err, timeout_err, mem_cs, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;

    mem_initiator #(.TIMEOUT_CYCLES(T)) dut (
        .clock      (clock),
        .cpu_rst    (cpu_rst),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .rdata      (rdata),
        .addr_err   (addr_err),
        .timeout_err(timeout_err),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clock = ~clock;

    int          total = 0, passed = 0;
    int          lat_cfg = 1000, cs_run = 0;
    int          cs_cnt = 0, we_cnt = 0, ae_cnt = 0, te_cnt = 0;
    logic        chk_en = 1'b0;
    logic        e_stall, e_cs, e_we, e_ae, e_te;
    logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0, prev = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
        #2;
    endtask

    task automatic set_exp(input logic st, input logic cs, input logic we, input logic ae, input logic te);
        e_stall = st; e_cs = cs; e_we = we; e_ae = ae; e_te = te; e_rdata = prev;
    endtask

    task automatic clr();
        cs_cnt = 0; we_cnt = 0; ae_cnt = 0; te_cnt = 0;
    endtask

    // Responder: acks on the falling edge once cs has been seen high lat_cfg times
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(negedge clock);
            if (mem_cs === 1'b1) begin
                cs_run++;
                mem_ack = cs_run >= lat_cfg;
            end else begin
                cs_run  = 0;
                mem_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            #1;
            if (mem_cs === 1'b1) cs_cnt++;
            if (mem_cs === 1'b1 && mem_we === 1'b1) we_cnt++;
            if (addr_err === 1'b1) ae_cnt++;
            if (timeout_err === 1'b1) te_cnt++;
            if (chk_en) begin
                check("stall", stall, e_stall);
                check("mem_cs", mem_cs, e_cs);
                check("mem_we", mem_we, e_we);
                check("rdata", rdata, e_rdata);
                check("addr_err", addr_err, e_ae);
                check("timeout_err", timeout_err, e_te);
                if (e_cs) begin
                    check("mem_addr", mem_addr, e_addr);
                    check("mem_wdata", mem_wdata, e_wdata);
                end
            end
        end
    end

    // One request held until the pipeline is released, then an idle cycle
    task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                           input int lat, input logic [31:0] rsp);
        int   n;
        logic to;
        logic ok;
        ok = a[1:0] == 2'b00;
        lat_cfg = lat;
        step();
        req_read = rd; req_write = wr; req_addr = a; req_wdata = d; mem_rdata = rsp;
        e_addr = a; e_wdata = d;
        set_exp(ok, 1'b0, 1'b0, 1'b0, 1'b0);
        if (!ok) begin
            step();
            req_read = 1'b0; req_write = 1'b0;
            set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            step();
            set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end
        n  = lat <= T ? lat : T;
        to = lat > T;
        for (int i = 0; i < n; i++) begin
            step();
            set_exp(1'b1, 1'b1, wr, 1'b0, 1'b0);
        end
        step();
        if (rd && !wr && !to) prev = rsp;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, to);
        step();
        req_read = 1'b0; req_write = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        cpu_rst = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;
        step();
        step();
        sample();
        check("rst_stall", stall, 1'b0);
        check("rst_cs", mem_cs, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addr_err", addr_err, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        step();
        cpu_rst = 1'b0; req_read = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;

        clr();
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, 2, 32'hDEADBEEF);
        sample();
        check("read_cs_cycles", cs_cnt, 2);
        check("read_we_cycles", we_cnt, 0);
        check("read_rdata", rdata, 32'hDEADBEEF);

        clr();
        run_txn(1'b0, 1'b1, 32'h20, 32'h12345678, 3, 32'hCAFEF00D);
        sample();
        check("write_we_cycles", we_cnt, 3);
        check("write_rdata_kept", rdata, 32'hDEADBEEF);

        clr();
        run_txn(1'b1, 1'b0, 32'h13, 32'h0, 2, 32'h0);
        sample();
        check("misaligned_addr_err", ae_cnt, 1);
        check("misaligned_cs", cs_cnt, 0);

        clr();
        run_txn(1'b1, 1'b0, 32'h40, 32'h0, 1000, 32'h11111111);
        sample();
        check("timeout_cs_cycles", cs_cnt, T);
        check("timeout_pulses", te_cnt, 1);
        check("timeout_rdata_kept", rdata, 32'hDEADBEEF);

        clr();
        run_txn(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 2, 32'h22222222);
        sample();
        check("both_we_cycles", we_cnt, 2);
        check("both_rdata_kept", rdata, 32'hDEADBEEF);

        clr();
        run_txn(1'b1, 1'b0, 32'h44, 32'h0, T, 32'h33333333);
        sample();
        check("ack_at_limit_no_timeout", te_cnt, 0);
        check("ack_at_limit_rdata", rdata, 32'h33333333);

        chk_en = 1'b0;
        lat_cfg = 1000;
        step();
        req_read = 1'b1; req_write = 1'b0; req_addr = 32'h50;
        step();
        step();
        step();
        cpu_rst = 1'b1; req_read = 1'b0;
        sample();
        check("rst_in_access_stall", stall, 1'b0);
        step();
        req_read = 1'b1; req_addr = 32'h0;
        sample();
        check("abort_cs", mem_cs, 1'b0);
        check("abort_we", mem_we, 1'b0);
        check("abort_addr", mem_addr, 32'h0);
        check("abort_wdata", mem_wdata, 32'h0);
        check("abort_rdata", rdata, 32'h0);
        check("abort_addr_err", addr_err, 1'b0);
        check("abort_timeout_err", timeout_err, 1'b0);
        check("abort_req_stall", stall, 1'b0);
        step();
        cpu_rst = 1'b0; req_read = 1'b0;
        sample();
        check("req_in_rst_ignored", mem_cs, 1'b0);
        prev = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;

        for (int k = 0; k < 40; k++) begin
            int          kind, lat;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            a = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            lat = $urandom_range(0, 7) == 0 ? 1000 : $urandom_range(1, T + 3);
            run_txn(kind != 1, kind != 0, a, $urandom, lat, $urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
        sample();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS cycles to wait for mem_ack.
REQ-002 The block SHALL have port clock  in  1  single system clock, all state on rising edge.
REQ-003 The block SHALL have port cpu_rst  in  1  reset, synchronous, active-high.
REQ-004 The block SHALL have ports req_read and req_write, each in 1, meaning a load or store request from the MEM stage.
REQ-005 The block SHALL have ports req_addr and req_wdata, each in 32, meaning the byte address and the store data.
REQ-006 The block SHALL have port stall  out  1  freeze pipeline.
REQ-007 The block SHALL have port rdata  out  32  load result.
REQ-008 The block SHALL have ports addr_err and timeout_err, each out 1, meaning single-cycle error pulses.
REQ-009 The block SHALL have ports mem_cs and mem_we, each out 1, meaning chip select and write enable to the memory responder.
REQ-010 The block SHALL have ports mem_addr and mem_wdata, each out 32, meaning the address and write data to the responder.
REQ-011 The block SHALL have ports mem_ack (in 1) and mem_rdata (in 32), meaning the responder acknowledge and read data.

Function
REQ-012 The FSM SHALL have three states: IDLE, ACCESS and RELEASE.
REQ-013 In IDLE, a request (req_read|req_write) with req_addr[1:0]==0 SHALL be accepted.
- Accepting latches addr, wdata and we=req_write.
- Next state is ACCESS.
REQ-014 When req_read and req_write are asserted together, the access SHALL be treated as a write.
REQ-015 In IDLE, a request with req_addr[1:0]!=0 SHALL pulse addr_err for exactly one cycle.
- No access is performed, stall=0, and the state stays IDLE.
REQ-016 In ACCESS, mem_cs SHALL be 1 and mem_we SHALL equal the latched we.
- mem_addr and mem_wdata are driven from the latches, stable for the whole access.
REQ-017 In ACCESS, a wait counter SHALL increment each cycle.
- On mem_ack==1: rdata<=mem_rdata for reads only, rdata held for writes, next state RELEASE.
REQ-018 If the counter reaches TIMEOUT_CYCLES with mem_ack still 0, the block SHALL pulse timeout_err for one cycle and go to RELEASE.
- rdata is left unchanged.
REQ-019 If mem_ack and the timeout occur in the same cycle, ack SHALL win and no timeout_err is raised.
REQ-020 In RELEASE, mem_cs and mem_we SHALL be 0, and the state SHALL go to IDLE only when mem_ack==0.
REQ-021 stall SHALL be combinational, equal to 1 in these cases:
- IDLE with an accepted request;
- ACCESS;
- RELEASE while mem_ack==1.
Otherwise stall=0.
REQ-022 Outside ACCESS, mem_cs and mem_we SHALL be 0.
REQ-023 With a responder acking on the falling edge after cs, a read accepted at cycle 0 SHALL complete as follows:
- ACCESS in cycles 1-2, with ack seen at cycle 2;
- RELEASE in cycle 3, with stall=0 once ack has fallen;
- rdata valid from cycle 3.
REQ-024 rdata SHALL hold its last load value until the next successful read.
REQ-025 A new request SHALL NOT be accepted before the state returns to IDLE.

Reset
REQ-026 When cpu_rst=1 at a rising edge, the block SHALL apply the following reset values:
- state=IDLE and counter=0;
- mem_cs=0, mem_we=0, mem_addr=0, mem_wdata=0;
- rdata=0, addr_err=0, timeout_err=0.
REQ-027 A reset during ACCESS or RELEASE SHALL abort the access immediately, with mem_cs=0 in the following cycle.
REQ-028 While cpu_rst=1, requests SHALL be ignored and stall SHALL be 0.

Structure
REQ-029 The FSM state encoding and the default timeout constant SHALL live in the shared package mem_if_pkg, so the responder and the bench can reuse them.
REQ-030 The wait counter SHALL be a sub-module named mem_timeout_counter, with enable/clear inputs and an expired output.

Verification
REQ-031 Aligned read 0x00000010, responder returns 0xDEADBEEF -> the bench SHALL see:
- mem_cs high in cycles 1-2 and mem_we=0;
- rdata=0xDEADBEEF from cycle 3;
- stall low at cycle 3.
REQ-032 Write 0x00000020, data 0x12345678 -> the bench SHALL see mem_we=1 with cs, mem_wdata=0x12345678 stable, and rdata unchanged.
REQ-033 Read at 0x00000013 -> the bench SHALL see addr_err high for one cycle, mem_cs never high, and stall=0.
REQ-034 Responder never acks with TIMEOUT_CYCLES=16 -> the bench SHALL see timeout_err pulse at the 16th ACCESS cycle, then IDLE, with rdata unchanged.
REQ-035 cpu_rst asserted during ACCESS -> the bench SHALL see mem_cs=0 and the state IDLE next cycle, and all outputs at their reset values.
REQ-036 req_read and req_write both high -> the bench SHALL see the access performed as a write (mem_we=1).
